// File: rtl/traffic_light_ctrl_if.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_if
//   Bundles the time base, mode/sensor inputs and lamp-pad outputs of the
//   traffic-light sequencer.
//
//   Strobe contract: tick is a single-clk pulse synchronous to clk. The
//   controller counts one tick on every clk edge where tick = 1, so a tick held
//   high for N clocks counts N times. The source must therefore deliver exactly
//   one cycle per time-base period. enable, side_car and ped_req are plain
//   levels sampled on every clk edge. All outputs are registered.
//
//   Signals:
//     tick       time-base pulse          (master -> slave)
//     enable     1 normal, 0 fail-safe    (master -> slave)
//     side_car   side-road sensor level   (master -> slave)
//     ped_req    pedestrian button        (master -> slave)
//     main_lamp  {red,yellow,green} main  (slave -> master)
//     side_lamp  {red,yellow,green} side  (slave -> master)
//     walk       walk lamp                (slave -> master)
//     dont_walk  don't-walk lamp          (slave -> master)
//     ped_wait   request registered       (slave -> master)
//     state_dbg  current state encoding   (slave -> master)
// -----------------------------------------------------------------------------
interface traffic_light_ctrl_if;
  logic       tick;
  logic       enable;
  logic       side_car;
  logic       ped_req;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk;
  logic       dont_walk;
  logic       ped_wait;
  logic [3:0] state_dbg;

  modport master (
    output tick, enable, side_car, ped_req,
    input  main_lamp, side_lamp, walk, dont_walk, ped_wait, state_dbg
  );

  modport slave (
    input  tick, enable, side_car, ped_req,
    output main_lamp, side_lamp, walk, dont_walk, ped_wait, state_dbg
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//   Tick-driven sequencer for a main road, a side road and a pedestrian
//   crossing. Every phase lasts a whole number of ticks; side-road and
//   pedestrian demand are latched into pending flags and served after the
//   minimum main green. enable = 0 drops into a flashing fail-safe mode.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    traffic_light_ctrl_if.slave (tick, enable, side_car, ped_req in;
//            lamps, ped_wait, state_dbg out)
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int MAIN_GREEN_T = 20,
  parameter int SIDE_GREEN_T = 10,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 1,
  parameter int WALK_T       = 8,
  parameter int CLEAR_T      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ctrl_if.slave  bus
);

  if (MAIN_GREEN_T < 1 || MAIN_GREEN_T > 255 || SIDE_GREEN_T < 1 || SIDE_GREEN_T > 255 ||
      YELLOW_T < 1 || YELLOW_T > 255 || ALLRED_T < 1 || ALLRED_T > 255 ||
      WALK_T < 1 || WALK_T > 255 || CLEAR_T < 1 || CLEAR_T > 255) begin : g_bad_duration
    $error("traffic_light_ctrl: every duration parameter must be in 1..255");
  end

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_MAIN_G = 4'd1,
    S_MAIN_Y = 4'd2,
    S_AR1    = 4'd3,
    S_SIDE_G = 4'd4,
    S_SIDE_Y = 4'd5,
    S_AR2    = 4'd6,
    S_WALK   = 4'd7,
    S_CLEAR  = 4'd8,
    S_FLASH  = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       flash_q, flash_d;
  logic       side_pending_q, side_pending_d;
  logic       ped_pending_q, ped_pending_d;
  logic [2:0] main_lamp_q, main_lamp_d;
  logic [2:0] side_lamp_q, side_lamp_d;
  logic       walk_q, walk_d;
  logic       dont_walk_q, dont_walk_d;
  logic       expired;

  // Timer reload value (duration - 1) for the state being entered.
  function automatic logic [7:0] dur_m1(state_e s);
    case (s)
      S_INIT, S_AR1, S_AR2: dur_m1 = 8'(ALLRED_T - 1);
      S_MAIN_G:             dur_m1 = 8'(MAIN_GREEN_T - 1);
      S_MAIN_Y, S_SIDE_Y:   dur_m1 = 8'(YELLOW_T - 1);
      S_SIDE_G:             dur_m1 = 8'(SIDE_GREEN_T - 1);
      S_WALK:               dur_m1 = 8'(WALK_T - 1);
      S_CLEAR:              dur_m1 = 8'(CLEAR_T - 1);
      default:              dur_m1 = 8'd0;
    endcase
  endfunction

  assign expired = bus.tick && (timer_q == 8'd0);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    flash_d        = 1'b0;
    side_pending_d = side_pending_q;
    ped_pending_d  = ped_pending_q;
    main_lamp_d    = 3'b100;
    side_lamp_d    = 3'b100;
    walk_d         = 1'b0;
    dont_walk_d    = 1'b1;

    // Next state: fail-safe first, then leaving FLASH, then phase expiry.
    if (!bus.enable) begin
      state_d = S_FLASH;
    end else if (state_q == S_FLASH) begin
      state_d = S_INIT;
    end else if (expired) begin
      case (state_q)
        S_INIT:   state_d = S_MAIN_G;
        // Without demand MAIN_G simply stays, timer parked at 0, so the
        // first tick after a flag rises moves on.
        S_MAIN_G: if (side_pending_q || ped_pending_q) state_d = S_MAIN_Y;
        S_MAIN_Y: state_d = S_AR1;
        S_AR1:    state_d = side_pending_q ? S_SIDE_G : S_WALK;
        S_SIDE_G: state_d = S_SIDE_Y;
        S_SIDE_Y: state_d = S_AR2;
        S_AR2:    state_d = ped_pending_q ? S_WALK : S_MAIN_G;
        S_WALK:   state_d = S_CLEAR;
        S_CLEAR:  state_d = S_MAIN_G;
        default:  state_d = S_INIT;
      endcase
    end

    // The transitioning tick is not counted in the new state.
    if (state_d != state_q) begin
      timer_d = dur_m1(state_d);
    end else if (bus.tick && timer_q != 8'd0) begin
      timer_d = timer_q - 8'd1;
    end

    // flash doubles as the CLEAR don't-walk phase: starts at 1, flips per tick.
    if (state_d == S_FLASH || state_d == S_CLEAR) begin
      flash_d = (state_d != state_q) ? 1'b1 : (flash_q ^ bus.tick);
    end

    if (bus.side_car && state_q != S_SIDE_G) side_pending_d = 1'b1;
    if (bus.ped_req && state_q != S_WALK)    ped_pending_d  = 1'b1;
    // Entry clears override a same-cycle set.
    if (state_d == S_SIDE_G) side_pending_d = 1'b0;
    if (state_d == S_WALK)   ped_pending_d  = 1'b0;
    if (state_d == S_FLASH || state_q == S_FLASH) begin
      side_pending_d = 1'b0;
      ped_pending_d  = 1'b0;
    end

    // Lamps are registered from the next state so they change with state_q.
    case (state_d)
      S_MAIN_G: main_lamp_d = 3'b001;
      S_MAIN_Y: main_lamp_d = 3'b010;
      S_SIDE_G: side_lamp_d = 3'b001;
      S_SIDE_Y: side_lamp_d = 3'b010;
      S_WALK: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end
      S_CLEAR:  dont_walk_d = flash_d;
      S_FLASH: begin
        main_lamp_d = {1'b0, flash_d, 1'b0};
        side_lamp_d = {flash_d, 2'b00};
        dont_walk_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_INIT;
      timer_q        <= 8'(ALLRED_T - 1);
      flash_q        <= 1'b0;
      side_pending_q <= 1'b0;
      ped_pending_q  <= 1'b0;
      main_lamp_q    <= 3'b100;
      side_lamp_q    <= 3'b100;
      walk_q         <= 1'b0;
      dont_walk_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      flash_q        <= flash_d;
      side_pending_q <= side_pending_d;
      ped_pending_q  <= ped_pending_d;
      main_lamp_q    <= main_lamp_d;
      side_lamp_q    <= side_lamp_d;
      walk_q         <= walk_d;
      dont_walk_q    <= dont_walk_d;
    end
  end

  assign bus.main_lamp = main_lamp_q;
  assign bus.side_lamp = side_lamp_q;
  assign bus.walk      = walk_q;
  assign bus.dont_walk = dont_walk_q;
  assign bus.ped_wait  = ped_pending_q;
  assign bus.state_dbg = state_q;

endmodule
